// File: rtl/ysyx_25040101_defs.sv
// ysyx_25040101_defs: shared FSM state encodings and load funct3 codes
package ysyx_25040101_defs;
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_COMMIT   = 2'd2,
    S_HALT     = 2'd3
  } wbu_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/ysyx_25040101_load_ext.sv
// ysyx_25040101_load_ext: selects and extends the loaded byte/half/word from an aligned read word
module ysyx_25040101_load_ext
  import ysyx_25040101_defs::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  // byte picked by the full offset, half by offset[1] only; unsupported codes give 0
  always_comb begin
    b    = word[{offset, 3'b000} +: 8];
    h    = offset[1] ? word[31:16] : word[15:0];
    data = funct3 == F3_LB  ? {{24{b[7]}}, b}  :
           funct3 == F3_LBU ? {24'd0, b}       :
           funct3 == F3_LH  ? {{16{h[15]}}, h} :
           funct3 == F3_LHU ? {16'd0, h}       :
           funct3 == F3_LW  ? word             : 32'd0;
  end
endmodule

// File: rtl/ysyx_25040101_wbu.sv
// ysyx_25040101_wbu: write-back unit with load wait, one-cycle commit, ebreak halt and retire counter
module ysyx_25040101_wbu
  import ysyx_25040101_defs::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [4:0]       in_rd_addr,
  input  logic             in_rd_wen,
  input  logic [XLEN-1:0]  in_alu_res,
  input  logic             in_is_load,
  input  logic [2:0]       in_funct3,
  input  logic             in_is_ebreak,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic [XLEN-1:0]  reg_a0_i,
  output logic [XLEN-1:0]  rd_data_o,
  output logic [4:0]       rd_addr_o,
  output logic             rd_wen_o,
  output logic             commit_valid_o,
  output logic [XLEN-1:0]  commit_pc_o,
  output logic             halted_o,
  output logic [XLEN-1:0]  exit_code_o,
  output logic [CNT_W-1:0] retire_cnt_o
);
  wbu_state_e      state_q;
  logic [XLEN-1:0] pc_q, data_q, exit_q;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic            wen_q, ebreak_q, commit_q, rd_wen_q, halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] ld_data;

  // data_q still holds the load address while waiting, so its low bits are the byte offset
  ysyx_25040101_load_ext u_load_ext (
    .funct3 (f3_q),
    .offset (data_q[1:0]),
    .word   (mem_rdata),
    .data   (ld_data)
  );

  // control FSM; commit strobes are registered on entry to COMMIT and cleared after one cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      data_q   <= '0;
      exit_q   <= '0;
      rd_q     <= '0;
      f3_q     <= '0;
      wen_q    <= 1'b0;
      ebreak_q <= 1'b0;
      commit_q <= 1'b0;
      rd_wen_q <= 1'b0;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      commit_q <= 1'b0;
      rd_wen_q <= 1'b0;
      case (state_q)
        S_IDLE: if (in_valid) begin
          pc_q     <= in_pc;
          data_q   <= in_alu_res;
          rd_q     <= in_rd_addr;
          f3_q     <= in_funct3;
          wen_q    <= in_rd_wen;
          ebreak_q <= in_is_ebreak;
          state_q  <= in_is_load ? S_WAIT_MEM : S_COMMIT;
          commit_q <= !in_is_load;
          rd_wen_q <= !in_is_load && in_rd_wen && in_rd_addr != 5'd0 && !in_is_ebreak;
        end
        S_WAIT_MEM: if (mem_rvalid) begin
          data_q   <= ld_data;
          state_q  <= S_COMMIT;
          commit_q <= 1'b1;
          rd_wen_q <= wen_q && rd_q != 5'd0 && !ebreak_q;
        end
        S_COMMIT: begin
          cnt_q   <= cnt_q + 1'b1;
          state_q <= ebreak_q ? S_HALT : S_IDLE;
          if (ebreak_q) begin
            exit_q   <= reg_a0_i;
            halted_q <= 1'b1;
          end
        end
        default: state_q <= S_HALT;
      endcase
    end
  end

  assign in_ready       = state_q == S_IDLE;
  assign rd_data_o      = data_q;
  assign rd_addr_o      = rd_q;
  assign rd_wen_o       = rd_wen_q;
  assign commit_valid_o = commit_q;
  assign commit_pc_o    = pc_q;
  assign halted_o       = halted_q;
  assign exit_code_o    = exit_q;
  assign retire_cnt_o   = cnt_q;
endmodule

// File: tb/tb_ysyx_25040101_wbu.sv
// tb_ysyx_25040101_wbu: table-driven directed checks of the write-back unit
module tb_ysyx_25040101_wbu;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_pc = '0, in_alu_res = '0, mem_rdata = '0, reg_a0_i = '0;
  logic [4:0]  in_rd_addr = '0;
  logic        in_rd_wen = 1'b0, in_is_load = 1'b0, in_is_ebreak = 1'b0, mem_rvalid = 1'b0;
  logic [2:0]  in_funct3 = '0;
  logic [31:0] rd_data_o, commit_pc_o, exit_code_o, retire_cnt_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wen_o, commit_valid_o, halted_o;
  int checks = 0, failures = 0;
  int exp_cnt = 0;

  typedef struct {
    logic        ld;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] word;
    int          waits;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] exp_data;
    logic        exp_wen;
  } vec_t;

  vec_t vecs [11];

  ysyx_25040101_wbu #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen), .in_alu_res(in_alu_res),
    .in_is_load(in_is_load), .in_funct3(in_funct3), .in_is_ebreak(in_is_ebreak),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .reg_a0_i(reg_a0_i),
    .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o),
    .commit_valid_o(commit_valid_o), .commit_pc_o(commit_pc_o), .halted_o(halted_o),
    .exit_code_o(exit_code_o), .retire_cnt_o(retire_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_wen"}, 32'(rd_wen_o), 32'd0);
    chk({tag, " commit_valid"}, 32'(commit_valid_o), 32'd0);
    chk({tag, " halted"}, 32'(halted_o), 32'd0);
    chk({tag, " rd_data"}, rd_data_o, 32'd0);
    chk({tag, " rd_addr"}, 32'(rd_addr_o), 32'd0);
    chk({tag, " commit_pc"}, commit_pc_o, 32'd0);
    chk({tag, " exit_code"}, exit_code_o, 32'd0);
    chk({tag, " retire_cnt"}, retire_cnt_o, 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic issue(input vec_t v, input logic [31:0] pc, input logic ebreak, input string tag);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_pc = pc; in_is_load = v.ld; in_funct3 = v.f3; in_alu_res = v.res;
    in_rd_addr = v.rd; in_rd_wen = v.wen; in_is_ebreak = ebreak;
    tick();
    in_valid = 1'b0; in_alu_res = 32'h0BAD_0BAD; in_pc = '0; in_rd_addr = '0;
    if (v.ld) begin
      for (int w = 0; w < v.waits; w++) begin
        chk({tag, " in_ready wait"}, 32'(in_ready), 32'd0);
        chk({tag, " commit wait"}, 32'(commit_valid_o), 32'd0);
        tick();
      end
      chk({tag, " in_ready wait"}, 32'(in_ready), 32'd0);
      mem_rvalid = 1'b1; mem_rdata = v.word;
      tick();
      mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    end
    chk({tag, " commit_valid"}, 32'(commit_valid_o), 32'd1);
    chk({tag, " rd_wen"}, 32'(rd_wen_o), 32'(v.exp_wen));
    chk({tag, " rd_data"}, rd_data_o, v.exp_data);
    chk({tag, " rd_addr"}, 32'(rd_addr_o), 32'(v.rd));
    chk({tag, " commit_pc"}, commit_pc_o, pc);
    chk({tag, " cnt before"}, retire_cnt_o, 32'(exp_cnt));
    tick();
    exp_cnt++;
    chk({tag, " cnt after"}, retire_cnt_o, 32'(exp_cnt));
    chk({tag, " commit drop"}, 32'(commit_valid_o), 32'd0);
    chk({tag, " wen drop"}, 32'(rd_wen_o), 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 3'b000, 32'h1234_5678, 32'h0,         0, 5'd5,  1'b1, 32'h1234_5678, 1'b1};
    vecs[1]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h80FF_0000, 4, 5'd6,  1'b1, 32'hFFFF_FF80, 1'b1};
    vecs[2]  = '{1'b1, 3'b100, 32'h0000_1003, 32'h80FF_0000, 4, 5'd6,  1'b1, 32'h0000_0080, 1'b1};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_2002, 32'h8001_7FFF, 1, 5'd7,  1'b1, 32'hFFFF_8001, 1'b1};
    vecs[4]  = '{1'b1, 3'b101, 32'h0000_2000, 32'h8001_7FFF, 2, 5'd8,  1'b1, 32'h0000_7FFF, 1'b1};
    vecs[5]  = '{1'b1, 3'b011, 32'h0000_2000, 32'h8001_7FFF, 0, 5'd9,  1'b1, 32'h0000_0000, 1'b1};
    vecs[6]  = '{1'b0, 3'b000, 32'hA5A5_0001, 32'h0,         0, 5'd0,  1'b1, 32'hA5A5_0001, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 32'h0000_3001, 32'hDEAD_BEEF, 0, 5'd31, 1'b1, 32'hDEAD_BEEF, 1'b1};
    vecs[8]  = '{1'b1, 3'b001, 32'h0000_3003, 32'h1234_F00D, 3, 5'd10, 1'b1, 32'h0000_1234, 1'b1};
    vecs[9]  = '{1'b1, 3'b000, 32'h0000_3001, 32'h0000_7F00, 1, 5'd11, 1'b1, 32'h0000_007F, 1'b1};
    vecs[10] = '{1'b0, 3'b000, 32'h0000_00FF, 32'h0,         0, 5'd12, 1'b0, 32'h0000_00FF, 1'b0};
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    chk_all_zero("reset");
    for (int i = 0; i < 11; i++) issue(vecs[i], 32'h8000_0000 + 32'(i * 4), 1'b0, $sformatf("v%0d", i));

    do_reset();
    v = vecs[1];
    issue(v, 32'h8000_0100, 1'b0, "post_reset_lb");
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_rd_addr = 5'd3; in_rd_wen = 1'b1;
    in_pc = 32'h8000_0200; in_alu_res = 32'h100;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rstwait in_ready", 32'(in_ready), 32'd0);
    do_reset();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 3; k++) begin
      chk("rstwait late commit", 32'(commit_valid_o), 32'd0);
      chk("rstwait late wen", 32'(rd_wen_o), 32'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    chk_all_zero("rstwait");

    v = vecs[0];
    issue(v, 32'h8000_0300, 1'b0, "pre_ebreak");
    v = '{1'b0, 3'b000, 32'h0000_0000, 32'h0, 0, 5'd1, 1'b1, 32'h0000_0000, 1'b0};
    reg_a0_i = 32'h0;
    issue(v, 32'h8000_0304, 1'b1, "ebreak0");
    chk("ebreak0 halted", 32'(halted_o), 32'd1);
    chk("ebreak0 exit", exit_code_o, 32'd0);
    in_valid = 1'b1; in_is_load = 1'b0; in_rd_addr = 5'd4; in_rd_wen = 1'b1; in_alu_res = 32'h77;
    reg_a0_i = 32'h1111_2222;
    for (int k = 0; k < 5; k++) begin
      chk("halt in_ready", 32'(in_ready), 32'd0);
      chk("halt commit", 32'(commit_valid_o), 32'd0);
      chk("halt wen", 32'(rd_wen_o), 32'd0);
      chk("halt cnt", retire_cnt_o, 32'(exp_cnt));
      chk("halt sticky", 32'(halted_o), 32'd1);
      chk("halt exit", exit_code_o, 32'd0);
      tick();
    end
    in_valid = 1'b0;

    do_reset();
    chk_all_zero("halt_reset");
    reg_a0_i = 32'hCAFE_F00D;
    v = '{1'b0, 3'b000, 32'h0000_0042, 32'h0, 0, 5'd2, 1'b1, 32'h0000_0042, 1'b0};
    chk("ebreak1 not halted yet", 32'(halted_o), 32'd0);
    issue(v, 32'h8000_0400, 1'b1, "ebreak1");
    chk("ebreak1 halted", 32'(halted_o), 32'd1);
    chk("ebreak1 exit", exit_code_o, 32'hCAFE_F00D);
    chk("ebreak1 in_ready", 32'(in_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ysyx_25040101_wbu.md
YSYX_25040101_WBU -- requirements
Module: ysyx_25040101_wbu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 supported.
REQ-002 SHALL have parameter CNT_W, default 32, retire counter width.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-low reset (rst=0 resets on a clk edge).
REQ-005 SHALL have port in_valid, input, 1, upstream (EXU/LSU) result valid.
REQ-006 SHALL have port in_ready, output, 1, WBU can accept a result.
REQ-007 SHALL have port in_pc, input, 32, PC of the instruction.
REQ-008 SHALL have port in_rd_addr, input, 5, destination register.
REQ-009 SHALL have port in_rd_wen, input, 1, instruction writes rd.
REQ-010 SHALL have port in_alu_res, input, 32, ALU result, or load address for loads.
REQ-011 SHALL have port in_is_load, input, 1, result comes from memory.
REQ-012 SHALL have port in_funct3, input, 3, load size/sign code.
REQ-013 SHALL have port in_is_ebreak, input, 1, instruction is ebreak.
REQ-014 SHALL have port mem_rvalid, input, 1, memory read data valid.
REQ-015 SHALL have port mem_rdata, input, 32, word-aligned read word.
REQ-016 SHALL have port reg_a0_i, input, 32, current a0 from register file.
REQ-017 SHALL have port rd_data_o, output, 32, register file write data.
REQ-018 SHALL have port rd_addr_o, output, 5, register file write address.
REQ-019 SHALL have port rd_wen_o, output, 1, register file write enable.
REQ-020 SHALL have port commit_valid_o, output, 1, one-cycle retire pulse.
REQ-021 SHALL have port commit_pc_o, output, 32, PC of the retiring instruction.
REQ-022 SHALL have port halted_o, output, 1, sticky ebreak halt.
REQ-023 SHALL have port exit_code_o, output, 32, a0 captured at ebreak.
REQ-024 SHALL have port retire_cnt_o, output, CNT_W, count of retired instructions.

Function
REQ-025 SHALL implement FSM states IDLE, WAIT_MEM, COMMIT, HALT.
REQ-026 SHALL assert in_ready only in IDLE; handshake is in_valid&&in_ready.
REQ-027 On handshake, SHALL latch all in_* fields; next state WAIT_MEM if in_is_load, else COMMIT.
REQ-028 WAIT_MEM SHALL hold until mem_rvalid=1, then latch extracted load data and go to COMMIT; mem_rvalid in any other state SHALL be ignored.
REQ-029 Load extraction SHALL use offset = latched alu_res[1:0]: LB/LBU (000/100) select byte at offset, sign/zero extend; LH/LHU (001/101) select half by offset[1], ignore offset[0]; LW (010) pass the word; funct3 011/110/111 yield 0.
REQ-030 COMMIT SHALL last exactly one cycle: rd_wen_o = latched wen && rd_addr != 0; rd_data_o = load data or alu_res; commit_valid_o=1; commit_pc_o = latched pc; retire_cnt_o increments by 1, wrapping at 2^CNT_W.
REQ-031 Outside COMMIT, rd_wen_o and commit_valid_o SHALL be 0.
REQ-032 Latency: non-load writes in the cycle after the handshake; a load writes in the cycle after mem_rvalid; maximum throughput is one instruction per 2 cycles.
REQ-033 An ebreak instruction SHALL commit normally, without writing rd, and go to HALT; in the COMMIT cycle it SHALL capture reg_a0_i into exit_code_o and set halted_o from the next cycle.
REQ-034 HALT SHALL be sticky until reset: in_ready=0, no writes, retire counter frozen.

Reset
REQ-035 When rst=0 at a clk edge, the block SHALL go to IDLE, abandoning any pending WAIT_MEM or COMMIT without a write.
REQ-036 Reset SHALL clear rd_wen_o, commit_valid_o, halted_o, rd_data_o, rd_addr_o, commit_pc_o, exit_code_o and retire_cnt_o to 0; in_ready SHALL be 1 from the first cycle after reset.

Structure
REQ-037 FSM state encodings and load funct3 constants SHALL live in the shared defines package ysyx_25040101_defs.
REQ-038 Load extraction SHALL be a combinational sub-module ysyx_25040101_load_ext (inputs funct3, offset, word; output data).

Verification
REQ-039 The bench SHALL cover: ALU op with rd=5, res=0x12345678 -> one cycle after the handshake rd_wen_o=1, rd_addr_o=5, rd_data_o=0x12345678, and retire_cnt_o goes 0->1.
REQ-040 The bench SHALL cover: LB at offset 3 with mem_rdata=0x80FF_0000 after 4 wait cycles -> in_ready=0 during the wait; after mem_rvalid the write is 0xFFFFFF80; with LBU the write is 0x00000080.
REQ-041 The bench SHALL cover: LH at offset 2 with word 0x8001_7FFF -> 0xFFFF8001; LHU at offset 0 -> 0x00007FFF; funct3=011 -> 0.
REQ-042 The bench SHALL cover: an instruction with rd=0 and wen=1 -> rd_wen_o stays 0, commit_valid_o=1, and the counter increments.
REQ-043 The bench SHALL cover: ebreak with reg_a0_i=0 -> exit_code_o=0 and halted_o=1; later in_valid is never accepted and the counter stays frozen.
REQ-044 The bench SHALL cover: rst=0 during WAIT_MEM followed by a late mem_rvalid -> no write, state IDLE, all outputs 0.
